// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the fifo_drain read-side consumer: FSM encodings,
// default geometry and a width helper.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } state_e;

  localparam int DEF_BYTES  = 4;
  localparam int DEF_RD_LAT = 1;

  // Width of a byte count that must be able to hold the value BYTES itself.
  function automatic int bytes_cnt_w(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

endpackage

// File: rtl/fifo_drain_word_buf2.sv
// Two-entry FIFO-ordered word buffer with valid/ready output; entry 0 is the
// head, so the presented word and byte count come straight from registers.
module word_buf2 #(
  parameter int W  = 32,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic [CW-1:0] push_bytes,
  input  logic          pop_ready,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] head_bytes,
  output logic          head_valid,
  output logic [1:0]    count
);

  logic [W-1:0]  data0_q, data0_d;
  logic [W-1:0]  data1_q, data1_d;
  logic [CW-1:0] bytes0_q, bytes0_d;
  logic [CW-1:0] bytes1_q, bytes1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;
  logic          push_ok;
  logic [1:0]    occ;

  always_comb begin
    data0_d  = data0_q;
    data1_d  = data1_q;
    bytes0_d = bytes0_q;
    bytes1_d = bytes1_q;
    pop      = pop_ready && (cnt_q != 2'd0);
    occ      = cnt_q - {1'b0, pop};
    push_ok  = push && (occ != 2'd2);

    if (pop) begin
      data0_d  = data1_q;
      bytes0_d = bytes1_q;
      data1_d  = '0;
      bytes1_d = '0;
    end

    // A pushed word lands behind whatever survives this cycle's pop.
    if (push_ok) begin
      if (occ == 2'd0) begin
        data0_d  = push_data;
        bytes0_d = push_bytes;
      end else begin
        data1_d  = push_data;
        bytes1_d = push_bytes;
      end
    end

    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0_q  <= '0;
      data1_q  <= '0;
      bytes0_q <= '0;
      bytes1_q <= '0;
      cnt_q    <= 2'd0;
    end else begin
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      bytes0_q <= bytes0_d;
      bytes1_q <= bytes1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_data  = data0_q;
  assign head_bytes = bytes0_q;
  assign head_valid = (cnt_q != 2'd0);
  assign count      = cnt_q;

endmodule

// File: rtl/fifo_drain.sv
// Read-side FIFO consumer: credit-gated pops, little-endian byte packing into
// words, flush of partial words, and a two-entry valid/ready output buffer.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int BYTES  = DEF_BYTES,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                    clkr,
  input  logic                    rst,
  input  logic                    e,
  output logic                    RREQ,
  input  logic [7:0]              RD,
  input  logic                    flush,
  output logic [8*BYTES-1:0]      out_data,
  output logic [$clog2(BYTES):0]  out_bytes,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int W  = 8 * BYTES;
  localparam int PW = $clog2(BYTES);
  localparam int OW = bytes_cnt_w(BYTES);
  localparam int HW = 6;

  state_e            state_q, state_d;
  logic [PW-1:0]     pack_cnt_q, pack_cnt_d;
  logic [W-1:0]      pack_data_q, pack_data_d;
  logic [1:0]        infl_q, infl_d;
  logic [RD_LAT-1:0] lat_q, lat_d;

  logic [1:0]    buf_cnt;
  logic          push;
  logic [W-1:0]  push_data;
  logic [OW-1:0] push_bytes;
  logic [HW-1:0] held;
  logic          can_pop;
  logic          capture;

  // Bytes committed inside the block: buffered words, packer and in flight.
  assign held    = HW'(buf_cnt) * HW'(BYTES) + HW'(pack_cnt_q) + HW'(infl_q);
  assign can_pop = held < HW'(2 * BYTES);
  assign RREQ    = !rst && !e && can_pop && (state_q == RUN);
  assign capture = lat_q[RD_LAT-1];

  always_comb begin
    state_d     = state_q;
    pack_cnt_d  = pack_cnt_q;
    pack_data_d = pack_data_q;
    push        = 1'b0;
    push_data   = '0;
    push_bytes  = '0;

    lat_d[0] = RREQ;
    for (int i = 1; i < RD_LAT; i++) begin
      lat_d[i] = lat_q[i-1];
    end
    infl_d = infl_q + {1'b0, RREQ} - {1'b0, capture};

    if (capture) begin
      pack_data_d[{pack_cnt_q, 3'b000} +: 8] = RD;
      if (pack_cnt_q == PW'(BYTES - 1)) begin
        push        = 1'b1;
        push_data   = pack_data_d;
        push_bytes  = OW'(BYTES);
        pack_data_d = '0;
        pack_cnt_d  = '0;
      end else begin
        pack_cnt_d = pack_cnt_q + PW'(1);
      end
    end

    // Full-word pushes only come from captures, which cannot occur in
    // FLUSH_EMIT because in-flight pops have drained by then.
    case (state_q)
      RUN: begin
        if (flush) state_d = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (infl_q == 2'd0) begin
          state_d = (pack_cnt_q == '0) ? RUN : FLUSH_EMIT;
        end
      end
      FLUSH_EMIT: begin
        if (buf_cnt != 2'd2) begin
          push        = 1'b1;
          push_data   = pack_data_q;
          push_bytes  = {1'b0, pack_cnt_q};
          pack_data_d = '0;
          pack_cnt_d  = '0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pack_cnt_q  <= '0;
      pack_data_q <= '0;
      infl_q      <= 2'd0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_data_q <= pack_data_d;
      infl_q      <= infl_d;
      lat_q       <= lat_d;
    end
  end

  word_buf2 #(
    .W  (W),
    .CW (OW)
  ) u_buf (
    .clk        (clkr),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .push_bytes (push_bytes),
    .pop_ready  (out_ready),
    .head_data  (out_data),
    .head_bytes (out_bytes),
    .head_valid (out_valid),
    .count      (buf_cnt)
  );

endmodule
